// File: rtl/uart_rx_sipo_if.sv
// Purpose: bundles the tick/serial inputs and the parallel frame outputs of the UART
//   receive SIPO stage so the stage and its driver share a single port.
// Ports: baud_tick, data_rx, parity_type (toward receiver);
//   raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active_flag (from receiver).
interface uart_rx_sipo_if;
  logic       baud_tick;
  logic       data_rx;
  logic [1:0] parity_type;
  logic [7:0] raw_data;
  logic       parity_bit;
  logic       start_bit;
  logic       stop_bit;
  logic       recieved_flag;
  logic       active_flag;

  // master: the side that drives the serial line and consumes frames
  modport master (
    output baud_tick, data_rx, parity_type,
    input  raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active_flag
  );

  // slave: the receiver itself
  modport slave (
    input  baud_tick, data_rx, parity_type,
    output raw_data, parity_bit, start_bit, stop_bit, recieved_flag, active_flag
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// Purpose: UART receive serial-in/parallel-out; oversamples rx, frames start/8 data/
//   optional parity/stop and passes every field through unjudged.
// Latency: fields + 1-cycle recieved_flag one clock after the stop-bit sample.
// Backpressure: none; each completed frame produces one flag and overwrites the fields.
// Ports: clock, reset_n (sync, active-low); bus (slave modport): baud_tick, data_rx,
//   parity_type in; raw_data, parity_bit, start_bit, stop_bit, recieved_flag,
//   active_flag out.
module uart_rx_sipo #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           clock,
  input  logic           reset_n,
  uart_rx_sipo_if.slave  bus
);

  localparam int          CW        = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic          armed;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_en;     // frame carries a parity bit (type latched at start)
  logic          start_s;
  logic          par_s;
  logic          stop_s;
  logic          done;       // stop bit just sampled; publish fields next clock

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state             <= S_IDLE;
      rx_meta           <= 1'b1;
      rx_s              <= 1'b1;
      armed             <= 1'b0;
      tick_cnt          <= '0;
      bit_cnt           <= '0;
      shreg             <= '0;
      par_en            <= 1'b0;
      start_s           <= 1'b0;
      par_s             <= 1'b1;
      stop_s            <= 1'b1;
      done              <= 1'b0;
      bus.raw_data      <= '0;
      bus.parity_bit    <= 1'b1;
      bus.start_bit     <= 1'b0;
      bus.stop_bit      <= 1'b1;
      bus.recieved_flag <= 1'b0;
      bus.active_flag   <= 1'b0;
    end else begin
      rx_meta <= bus.data_rx;
      rx_s    <= rx_meta;

      // Fields are copied as a group so the outputs never show a partial frame.
      bus.recieved_flag <= done;
      if (done) begin
        bus.raw_data   <= shreg;
        bus.parity_bit <= par_s;
        bus.start_bit  <= start_s;
        bus.stop_bit   <= stop_s;
      end
      done <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_s) begin
            armed <= 1'b1;
          end
          // Only a falling edge after the line was seen high starts a frame, so a
          // held-low break cannot retrigger.
          if (armed && !rx_s) begin
            state           <= S_START;
            tick_cnt        <= '0;
            bit_cnt         <= '0;
            par_en          <= (bus.parity_type == 2'b01) || (bus.parity_type == 2'b10);
            bus.active_flag <= 1'b1;
          end
        end

        S_START: begin
          if (bus.baud_tick) begin
            if (tick_cnt == HALF_LAST) begin
              // No false-start abort: the sample is kept and the frame runs on.
              start_s  <= rx_s;
              tick_cnt <= '0;
              state    <= S_DATA;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        S_DATA: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shreg    <= {rx_s, shreg[7:1]};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (par_en) begin
                  state <= S_PARITY;
                end else begin
                  par_s <= 1'b1;
                  state <= S_STOP;
                end
              end
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        S_PARITY: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              par_s    <= rx_s;
              state    <= S_STOP;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        S_STOP: begin
          if (bus.baud_tick) begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt        <= '0;
              stop_s          <= rx_s;
              done            <= 1'b1;
              // Returning mid stop bit lets a back-to-back start edge be caught;
              // a low stop (break) leaves the receiver unarmed until the line rises.
              armed           <= rx_s;
              state           <= S_IDLE;
              bus.active_flag <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
          end
        end

        default: begin
          state           <= S_IDLE;
          bus.active_flag <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
module tb_uart_rx_sipo;
  localparam int OS = 16;

  logic clock;
  logic reset_n;
  uart_rx_sipo_if ifc ();

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (ifc)
  );

  typedef struct {
    logic [1:0] ptype;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_raw;
    logic       exp_par;
    logic       exp_stop;
    int         nominal;
  } vec_t;

  typedef struct {
    logic [7:0] raw;
    logic       par;
    logic       st;
    logic       sp;
    int         tick;
  } obs_t;

  int   n_pass = 0;
  int   n_total = 0;
  int   tick_total = 0;
  int   last_start = 0;
  obs_t obs_q[$];
  vec_t vecs[8];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // baud_tick high on every other clock
  initial begin
    ifc.baud_tick = 1'b0;
    forever begin
      @(posedge clock);
      #1 ifc.baud_tick = ~ifc.baud_tick;
    end
  end

  always @(posedge clock) if (ifc.baud_tick) tick_total <= tick_total + 1;

  always @(negedge clock) begin
    if (ifc.recieved_flag === 1'b1)
      obs_q.push_back('{ifc.raw_data, ifc.parity_bit, ifc.start_bit, ifc.stop_bit, tick_total});
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clock);
      while (ifc.baud_tick !== 1'b1) @(posedge clock);
    end
    #1;
  endtask

  task automatic send_frame(input logic [1:0] ptype, input logic [7:0] d,
                            input logic p, input logic sp);
    ifc.parity_type = ptype;
    ifc.data_rx     = 1'b0;
    last_start      = tick_total;
    wait_ticks(OS);
    // flip parity presence mid-frame; the receiver must ignore it
    ifc.parity_type = {ptype[0], ~ptype[1]};
    for (int i = 0; i < 8; i++) begin
      ifc.data_rx = d[i];
      wait_ticks(OS);
    end
    if (ptype == 2'b01 || ptype == 2'b10) begin
      ifc.data_rx = p;
      wait_ticks(OS);
    end
    ifc.data_rx = sp;
    wait_ticks(OS);
  endtask

  task automatic check_frame(input string nm, input logic [7:0] er, input logic ep,
                             input logic es, input logic esp, input int nominal);
    obs_t o;
    int   lat;
    chk({nm, " flag_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      chk({nm, " raw_data"}, o.raw, er);
      chk({nm, " parity_bit"}, o.par, ep);
      chk({nm, " start_bit"}, o.st, es);
      chk({nm, " stop_bit"}, o.sp, esp);
      if (nominal > 0) begin
        lat = o.tick - last_start;
        n_total++;
        if (lat < nominal - 3 || lat > nominal + 3)
          $display("FAIL %s latency: got %0d ticks, expected %0d +/-3", nm, lat, nominal);
        else n_pass++;
      end
    end
    chk({nm, " raw_hold"}, ifc.raw_data, er);
    obs_q.delete();
  endtask

  initial begin
    logic [1:0] pt;
    logic [7:0] d;
    logic       p, sp, hp;
    int         gap;

    vecs[0] = '{2'b10, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, OS * 21 / 2};
    vecs[1] = '{2'b00, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, OS * 19 / 2};
    vecs[2] = '{2'b01, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, OS * 21 / 2};
    vecs[3] = '{2'b10, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, OS * 21 / 2};
    vecs[4] = '{2'b01, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, OS * 21 / 2};
    vecs[5] = '{2'b11, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, OS * 19 / 2};
    vecs[6] = '{2'b10, 8'h0F, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b1, OS * 21 / 2};
    vecs[7] = '{2'b01, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, OS * 21 / 2};

    reset_n         = 1'b0;
    ifc.data_rx     = 1'b1;
    ifc.parity_type = 2'b00;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("reset raw_data", ifc.raw_data, 8'h00);
    chk("reset parity_bit", ifc.parity_bit, 1'b1);
    chk("reset start_bit", ifc.start_bit, 1'b0);
    chk("reset stop_bit", ifc.stop_bit, 1'b1);
    chk("reset recieved_flag", ifc.recieved_flag, 1'b0);
    chk("reset active_flag", ifc.active_flag, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_ticks(8);

    // table-driven frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].ptype, vecs[i].data, vecs[i].par, vecs[i].stop);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_raw, vecs[i].exp_par, 1'b0,
                  vecs[i].exp_stop, vecs[i].nominal);
      ifc.data_rx = 1'b1;
      wait_ticks(4);
    end

    // break: stop low then line held low two bit times
    send_frame(2'b01, 8'h01, 1'b0, 1'b0);
    wait_ticks(2 * OS);
    check_frame("break", 8'h01, 1'b0, 1'b0, 1'b0, OS * 21 / 2);
    wait_ticks(OS);
    chk("break no_rearm flags", obs_q.size(), 0);
    chk("break no_rearm active", ifc.active_flag, 1'b0);
    ifc.data_rx = 1'b1;
    wait_ticks(OS);
    send_frame(2'b10, 8'h5A, 1'b0, 1'b1);
    check_frame("after_break", 8'h5A, 1'b0, 1'b0, 1'b1, OS * 21 / 2);

    // back-to-back even frames, no idle
    send_frame(2'b10, 8'h55, 1'b0, 1'b1);
    check_frame("b2b_first", 8'h55, 1'b0, 1'b0, 1'b1, OS * 21 / 2);
    send_frame(2'b10, 8'hAA, 1'b0, 1'b1);
    check_frame("b2b_second", 8'hAA, 1'b0, 1'b0, 1'b1, OS * 21 / 2);
    wait_ticks(4);

    // start glitch: 2-tick low pulse, rest of frame idle high
    ifc.parity_type = 2'b10;
    ifc.data_rx     = 1'b0;
    last_start      = tick_total;
    wait_ticks(2);
    ifc.data_rx = 1'b1;
    wait_ticks(OS * 12);
    check_frame("glitch", 8'hFF, 1'b1, 1'b1, 1'b1, 0);

    // reset mid-frame
    ifc.data_rx = 1'b0;
    wait_ticks(40);
    chk("midframe active", ifc.active_flag, 1'b1);
    reset_n     = 1'b0;
    ifc.data_rx = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("midreset raw_data", ifc.raw_data, 8'h00);
    chk("midreset parity_bit", ifc.parity_bit, 1'b1);
    chk("midreset start_bit", ifc.start_bit, 1'b0);
    chk("midreset stop_bit", ifc.stop_bit, 1'b1);
    chk("midreset active_flag", ifc.active_flag, 1'b0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_ticks(OS * 12);
    chk("midreset no_flag", obs_q.size(), 0);
    chk("midreset idle", ifc.active_flag, 1'b0);
    chk("midreset raw_kept", ifc.raw_data, 8'h00);
    obs_q.delete();

    // randomized frames against the reference model
    for (int n = 0; n < 30; n++) begin
      pt = 2'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      hp = (pt == 2'b01) || (pt == 2'b10);
      p  = ((pt == 2'b10) ? ^d : ~^d) ^ ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 7) != 0);
      send_frame(pt, d, p, sp);
      check_frame($sformatf("rand%0d", n), d, hp ? p : 1'b1, 1'b0, sp,
                  hp ? OS * 21 / 2 : OS * 19 / 2);
      gap = $urandom_range(0, 20);
      if (!sp && gap == 0) gap = 1;
      ifc.data_rx = 1'b1;
      if (gap > 0) wait_ticks(gap);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
